// File: rtl/uart_rx_edge_sampler.sv
// uart_rx_edge_sampler: bit timing and majority-vote data recovery for the UART receiver.
// Latency: bit_done is combinational on edge P-1; sampled_bit updates one cycle after edge mid+1
//          (two more cycles of line delay when UART_RX_SYNC_EN is defined).
// Backpressure: none; free-running while enable is high, the FSM owns all flow control.
//
// Ports:
//   CLK, RST        oversampling clock, asynchronous active-high reset
//   RX_IN           serial line, idle high
//   Prescale        oversampling ratio (8/16/32; anything else treated as 8), captured at enable rise
//   enable          counters run while high, cleared while low
//   data_samp_en    majority sampling active while high
//   edge_cnt        edge index inside current bit, 0..P-1
//   bit_cnt         frame bit position (start bit = 1), saturates at 15
//   bit_done        strobe on the last edge of each bit
//   sampled_bit     registered majority of three mid-bit samples
//
// Build option: define UART_RX_SYNC_EN to put a 2-flop synchronizer in front of the sampler.

module uart_rx_edge_sampler #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  enable,
  input  logic                  data_samp_en,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  bit_done,
  output logic                  sampled_bit
);

  localparam logic [PRESCALE_W-1:0] P8  = PRESCALE_W'(8);
  localparam logic [PRESCALE_W-1:0] P16 = PRESCALE_W'(16);
  localparam logic [PRESCALE_W-1:0] P32 = PRESCALE_W'(32);
  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
  localparam logic [3:0]            BIT_CNT_MAX = 4'd15;

  logic [PRESCALE_W-1:0] p_new;
  logic [PRESCALE_W-1:0] p_reg;
  logic                  en_q;
  logic [PRESCALE_W-1:0] mid;
  logic [PRESCALE_W-1:0] mid_m1;
  logic [PRESCALE_W-1:0] mid_p1;
  logic                  edge_last;
  logic                  line;
  logic                  samp_act;
  logic                  s0;
  logic                  s1;
  logic                  got0;
  logic                  got1;
  logic                  vote;

  // ---------------------------------------------------------------------------
  // Line conditioning
  // ---------------------------------------------------------------------------
`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], RX_IN};
    end
  end

  assign line = sync_q[1];
`else
  assign line = RX_IN;
`endif

  // ---------------------------------------------------------------------------
  // Prescale capture: only legal ratios pass, everything else falls back to 8.
  // ---------------------------------------------------------------------------
  always_comb begin
    p_new = P8;
    if (Prescale == P16 || Prescale == P32) begin
      p_new = Prescale;
    end
  end

  // The ratio is latched on the first enabled cycle. During that cycle edge_cnt
  // is 0, which can never match P-1 or a sample point for any legal P, so the
  // stale p_reg value used in that one cycle is harmless.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      p_reg <= P8;
      en_q  <= 1'b0;
    end else begin
      en_q <= enable;
      if (enable && !en_q) begin
        p_reg <= p_new;
      end
    end
  end

  assign mid       = p_reg >> 1;
  assign mid_m1    = mid - ONE;
  assign mid_p1    = mid + ONE;
  assign edge_last = (edge_cnt == (p_reg - ONE));
  assign bit_done  = enable && edge_last;

  // ---------------------------------------------------------------------------
  // Edge and bit counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      edge_cnt <= '0;
    end else if (!enable) begin
      edge_cnt <= '0;
    end else if (edge_last) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + ONE;
    end
  end

  // Reset value 0 is only visible until the first clock edge; idle value is 1.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bit_cnt <= 4'd0;
    end else if (!enable) begin
      bit_cnt <= 4'd1;
    end else if (bit_done && (bit_cnt != BIT_CNT_MAX)) begin
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Three-point majority sampling around mid-bit.
  // The third sample is taken straight from the line on edge mid+1 and voted
  // in the same cycle, so sampled_bit is already updated on edge mid+2.
  // got0/got1 make sure a vote only uses samples from the current bit; they
  // are dropped when enable falls so an aborted bit never updates the output.
  // ---------------------------------------------------------------------------
  assign samp_act = enable && data_samp_en;
  assign vote     = (s0 & s1) | (s0 & line) | (s1 & line);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s0          <= 1'b1;
      s1          <= 1'b1;
      got0        <= 1'b0;
      got1        <= 1'b0;
      sampled_bit <= 1'b1;
    end else if (!enable) begin
      got0 <= 1'b0;
      got1 <= 1'b0;
    end else begin
      if (samp_act && (edge_cnt == mid_m1)) begin
        s0   <= line;
        got0 <= 1'b1;
      end
      if (samp_act && (edge_cnt == mid)) begin
        s1   <= line;
        got1 <= 1'b1;
      end
      if (edge_cnt == mid_p1) begin
        got0 <= 1'b0;
        got1 <= 1'b0;
        if (samp_act && got0 && got1) begin
          sampled_bit <= vote;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_edge_sampler.sv
// tb_uart_rx_edge_sampler: scoreboard bench for the UART RX edge sampler.
// Latency: expectations are queued per frame before driving; a negedge monitor pops on bit_done.
// Backpressure: none; stimulus runs open-loop, every loop is bounded by frame length.

`timescale 1ns/1ps

module tb_uart_rx_edge_sampler;

  localparam int PW = 6;
`ifdef UART_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          CLK          = 1'b0;
  logic          RST          = 1'b0;
  logic          RX_IN        = 1'b1;
  logic          enable       = 1'b0;
  logic          data_samp_en = 1'b0;
  logic [PW-1:0] Prescale     = PW'(8);
  logic [PW-1:0] edge_cnt;
  logic [3:0]    bit_cnt;
  logic          bit_done;
  logic          sampled_bit;

  uart_rx_edge_sampler #(.PRESCALE_W(PW)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .Prescale     (Prescale),
    .enable       (enable),
    .data_samp_en (data_samp_en),
    .edge_cnt     (edge_cnt),
    .bit_cnt      (bit_cnt),
    .bit_done     (bit_done),
    .sampled_bit  (sampled_bit)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int   at;    // enabled-cycle index where the strobe must appear
    int   bcnt;  // bit_cnt at the strobe
    logic sbit;  // sampled_bit at the strobe
  } exp_t;

  exp_t exp_q[$];
  logic wave[$];   // raw line value per cycle of the frame
  logic fbits[$];  // frame bit values
  int   n_checks   = 0;
  int   n_fail     = 0;
  logic model_sbit = 1'b1;
  int   cur_p      = 8;
  bit   mon_on     = 1'b0;
  int   en_cyc     = 0;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic int eff_p(input int pres);
    return (pres == 16 || pres == 32) ? pres : 8;
  endfunction

  task automatic build_wave(input int p);
    wave.delete();
    foreach (fbits[b]) begin
      for (int c = 0; c < p; c++) wave.push_back(fbits[b]);
    end
  endtask

  // Reference model: each bit is P cycles; its value is the majority of the
  // line at offsets mid-1, mid, mid+1 (as seen after LAT cycles of sync delay).
  // A bit only updates the output if its last sample cycle is still enabled.
  task automatic frame(input int pres, input int pres_late, input logic dse, input int abort_cyc);
    int p;
    int mid;
    int total;
    p     = eff_p(pres);
    mid   = p / 2;
    total = (abort_cyc > 0) ? abort_cyc : fbits.size() * p;
    cur_p = p;
    for (int b = 0; b * p < total; b++) begin
      if (dse && (b * p + mid + 1 < total)) begin
        int ones;
        ones = 0;
        for (int k = -1; k <= 1; k++) begin
          int t;
          t = b * p + mid + k - LAT;
          ones += (t < 0) ? 1 : int'(wave[t]);
        end
        model_sbit = (ones >= 2);
      end
      if ((b + 1) * p - 1 < total)
        exp_q.push_back('{at: (b + 1) * p - 1, bcnt: (b + 1 > 15) ? 15 : b + 1, sbit: model_sbit});
    end

    @(posedge CLK); #1;
    enable       = 1'b1;
    data_samp_en = dse;
    Prescale     = PW'(pres);
    for (int c = 0; c < total; c++) begin
      if (c > 0) begin
        @(posedge CLK); #1;
      end
      RX_IN = wave[c];
      if (pres_late != 0 && c == p) Prescale = PW'(pres_late);
    end
    @(posedge CLK); #1;
    enable       = 1'b0;
    data_samp_en = 1'b0;
    RX_IN        = 1'b1;
    @(negedge CLK);
    check("bit_done_after_drop", int'(bit_done), 0);
    @(negedge CLK);
    check("idle_edge_cnt", int'(edge_cnt), 0);
    check("idle_bit_cnt", int'(bit_cnt), 1);
    check("idle_sampled_bit", int'(sampled_bit), int'(model_sbit));
    check("strobes_missing", exp_q.size(), 0);
    exp_q.delete();
    repeat ($urandom_range(1, 4)) @(posedge CLK);
  endtask

  // Monitor: strobe timing, counter values and voted bit against the queue.
  always @(negedge CLK) begin
    if (mon_on && enable) begin
      logic want;
      want = (exp_q.size() > 0) && (exp_q[0].at == en_cyc);
      check("edge_cnt", int'(edge_cnt), en_cyc % cur_p);
      check("bit_done", int'(bit_done), int'(want));
      if (bit_done && want) begin
        exp_t e;
        e = exp_q.pop_front();
        check("bit_cnt_at_strobe", int'(bit_cnt), e.bcnt);
        check("sampled_bit_at_strobe", int'(sampled_bit), int'(e.sbit));
      end
      en_cyc++;
    end else begin
      en_cyc = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached with %0d checks done", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int pres_tab[6];
    pres_tab = '{8, 16, 32, 12, 0, 5};

    // Reset values and first-edge behaviour of bit_cnt.
    #1 RST = 1'b1;
    #2;
    check("rst_edge_cnt", int'(edge_cnt), 0);
    check("rst_bit_cnt", int'(bit_cnt), 0);
    check("rst_sampled_bit", int'(sampled_bit), 1);
    check("rst_bit_done", int'(bit_done), 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1 check("bit_cnt_before_first_edge", int'(bit_cnt), 0);
    @(posedge CLK); #1;
    check("bit_cnt_after_first_edge", int'(bit_cnt), 1);
    mon_on = 1'b1;

    // Byte 0xA5, P=8: start, 1,0,1,0,0,1,0,1, stop.
    fbits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    build_wave(8);
    frame(8, 0, 1'b1, 0);

    // Glitch votes at P=16: one low sample is outvoted, two are not.
    fbits = '{1'b0, 1'b1};
    build_wave(16);
    wave[16 + 8] = 1'b0;
    frame(16, 0, 1'b1, 0);
    build_wave(16);
    wave[16 + 7] = 1'b0;
    wave[16 + 8] = 1'b0;
    frame(16, 0, 1'b1, 0);

    // Abort at edge 5 of bit 3.
    fbits = '{1'b0, 1'b0, 1'b1, 1'b1};
    build_wave(16);
    frame(16, 0, 1'b1, 2 * 16 + 5);

    // Illegal prescale, then a mid-frame change that must wait for re-enable.
    fbits = '{1'b0, 1'b1, 1'b1};
    build_wave(8);
    frame(12, 32, 1'b1, 0);
    fbits = '{1'b0, 1'b1};
    build_wave(32);
    frame(32, 0, 1'b1, 0);

    // Saturation over 20 bits.
    fbits.delete();
    for (int i = 0; i < 20; i++) fbits.push_back(1'($urandom_range(0, 1)));
    build_wave(8);
    frame(8, 0, 1'b1, 0);

    // Randomized frames.
    for (int i = 0; i < 8; i++) begin
      int pres;
      int p;
      int nb;
      int ab;
      logic dse;
      pres = pres_tab[$urandom_range(0, 5)];
      p    = eff_p(pres);
      nb   = $urandom_range(1, 16);
      fbits.delete();
      for (int b = 0; b < nb; b++) fbits.push_back(1'($urandom_range(0, 1)));
      build_wave(p);
      repeat (3) begin
        int idx;
        idx = $urandom_range(0, nb * p - 1);
        wave[idx] = ~wave[idx];
      end
      dse = ($urandom_range(0, 3) != 0);
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nb * p - 1) : 0;
      frame(pres, 0, dse, ab);
    end

    // Reset asserted mid-bit acts without waiting for a clock edge.
    mon_on = 1'b0;
    @(posedge CLK); #1;
    enable       = 1'b1;
    data_samp_en = 1'b1;
    Prescale     = PW'(8);
    repeat (11) @(posedge CLK);
    #3 RST = 1'b1;
    #1;
    check("midbit_rst_edge_cnt", int'(edge_cnt), 0);
    check("midbit_rst_bit_cnt", int'(bit_cnt), 0);
    check("midbit_rst_sampled_bit", int'(sampled_bit), 1);
    check("midbit_rst_bit_done", int'(bit_done), 0);
    enable       = 1'b0;
    data_samp_en = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    check("post_rst_bit_cnt", int'(bit_cnt), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
